// File: rtl/dbg_mode_ctrl_pkg.sv
// Shared definitions for the debug-mode controller: FSM state encodings,
// dcsr.cause codes, the dpc source select and the drain counter width.
package dbg_mode_ctrl_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      ST_RUN    = 3'd0,
      ST_DRAIN  = 3'd1,
      ST_HALTED = 3'd2,
      ST_RESUME = 3'd3,
      ST_STEP   = 3'd4
   } dbg_state_e;

   typedef enum logic [2:0] {
      CAUSE_NONE    = 3'd0,
      CAUSE_EBREAK  = 3'd1,
      CAUSE_TRIGGER = 3'd2,
      CAUSE_HALTREQ = 3'd3,
      CAUSE_STEP    = 3'd4
   } dbg_cause_e;

   // Which PC is captured into dpc on debug entry.
   typedef enum logic [1:0] {
      DPC_SRC_PC_EX_Q = 2'd0,   // breakpoint: registered upstream, so one cycle old
      DPC_SRC_PC_EX   = 2'd1,   // ebreak / haltreq: instruction currently in EX
      DPC_SRC_NEXT_PC = 2'd2    // step completion: instruction after the retired one
   } dpc_src_e;

endpackage

// File: rtl/dbg_mode_ctrl_if.sv
// Signal bundle between the debug-mode controller and its neighbours
// (trigger unit, pipeline control, debug module, debug CSRs).
//
// Handshake semantics: haltreq and resumereq are level requests from the
// debug module. A resume is accepted only in HALTED and is acknowledged by a
// single-cycle resumeack; a request still held high after the ack is not
// accepted again until the core has returned to HALTED. breakpoint,
// ebreak_ex, instr_retire and dpc_wr are single-cycle qualifiers; pipe_flush
// and pc_redirect are single-cycle strobes; pipe_stall and dbg_mode are levels.
interface dbg_mode_ctrl_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  breakpoint;
   logic                  ebreak_ex;
   logic                  haltreq;
   logic                  resumereq;
   logic                  dret_ex;
   logic                  dcsr_step;
   logic [ADDR_WIDTH-1:0] pc_ex;
   logic [ADDR_WIDTH-1:0] next_pc_ex;
   logic                  instr_retire;
   logic                  pipe_idle;
   logic                  dpc_wr;
   logic [ADDR_WIDTH-1:0] dpc_wr_data;
   logic                  dbg_mode;
   logic                  halted;
   logic                  resumeack;
   logic                  pipe_flush;
   logic                  pipe_stall;
   logic                  pc_redirect;
   logic [ADDR_WIDTH-1:0] pc_redirect_addr;
   logic [ADDR_WIDTH-1:0] dpc;
   logic [2:0]            dcsr_cause;

   // Core side driving the controller's inputs.
   modport master (
      output breakpoint, ebreak_ex, haltreq, resumereq, dret_ex, dcsr_step,
             pc_ex, next_pc_ex, instr_retire, pipe_idle, dpc_wr, dpc_wr_data,
      input  dbg_mode, halted, resumeack, pipe_flush, pipe_stall,
             pc_redirect, pc_redirect_addr, dpc, dcsr_cause
   );

   // The debug-mode controller itself.
   modport slave (
      input  breakpoint, ebreak_ex, haltreq, resumereq, dret_ex, dcsr_step,
             pc_ex, next_pc_ex, instr_retire, pipe_idle, dpc_wr, dpc_wr_data,
      output dbg_mode, halted, resumeack, pipe_flush, pipe_stall,
             pc_redirect, pc_redirect_addr, dpc, dcsr_cause
   );
endinterface

// File: rtl/dbg_mode_ctrl_cause_arb.sv
// Priority encoder for debug-entry events. Inputs arrive already qualified
// by the FSM state; this block only ranks them and picks cause/dpc source.
module dbg_mode_ctrl_cause_arb
   import dbg_mode_ctrl_pkg::*;
(
   input  logic       breakpoint,
   input  logic       ebreak,
   input  logic       haltreq,
   input  logic       step_done,
   output logic       entry,
   output dbg_cause_e cause,
   output dpc_src_e   dpc_src
);

   // Fixed priority: trigger > ebreak > haltreq > step completion.
   always_comb begin
      entry   = 1'b0;
      cause   = CAUSE_NONE;
      dpc_src = DPC_SRC_PC_EX;
      if (breakpoint) begin
         entry   = 1'b1;
         cause   = CAUSE_TRIGGER;
         dpc_src = DPC_SRC_PC_EX_Q;
      end else if (ebreak) begin
         entry   = 1'b1;
         cause   = CAUSE_EBREAK;
         dpc_src = DPC_SRC_PC_EX;
      end else if (haltreq) begin
         entry   = 1'b1;
         cause   = CAUSE_HALTREQ;
         dpc_src = DPC_SRC_PC_EX;
      end else if (step_done) begin
         entry   = 1'b1;
         cause   = CAUSE_STEP;
         dpc_src = DPC_SRC_NEXT_PC;
      end
   end

endmodule

// File: rtl/dbg_mode_ctrl.sv
// Debug-mode controller: sequences the core RUN -> DRAIN -> HALTED ->
// RESUME -> RUN/STEP, captures dpc and dcsr.cause on entry, flushes and
// drains the pipeline, and redirects the PC to dpc on resume or dret.
module dbg_mode_ctrl
   import dbg_mode_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DRAIN_MAX  = 15
) (
   input  logic       cpu_clk,
   input  logic       cpu_rst,
   dbg_mode_ctrl_if.slave bus,
   output dbg_state_e dbg_state
);

   dbg_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] dpc_q, dpc_d;
   dbg_cause_e            cause_q, cause_d;
   logic [ADDR_WIDTH-1:0] pc_ex_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  dbg_mode_q, halted_q, resumeack_q, pipe_stall_q, pc_redirect_q;
   logic                  pipe_flush;

   logic       arb_entry;
   dbg_cause_e arb_cause;
   dpc_src_e   arb_dpc_src;
   logic       in_run, in_step;

   assign in_run  = (state_q == ST_RUN);
   assign in_step = (state_q == ST_STEP);

   // haltreq is held off during a step so the step completes with cause STEP.
   dbg_mode_ctrl_cause_arb u_cause_arb (
      .breakpoint (bus.breakpoint & (in_run | in_step)),
      .ebreak     (bus.ebreak_ex  & (in_run | in_step)),
      .haltreq    (bus.haltreq    & in_run),
      .step_done  (bus.instr_retire & in_step),
      .entry      (arb_entry),
      .cause      (arb_cause),
      .dpc_src    (arb_dpc_src)
   );

   // Next-state, dpc/cause capture and drain counting.
   always_comb begin
      state_d    = state_q;
      dpc_d      = dpc_q;
      cause_d    = cause_q;
      cnt_d      = cnt_q;
      pipe_flush = 1'b0;
      case (state_q)
         ST_RUN, ST_STEP: begin
            if (arb_entry) begin
               case (arb_dpc_src)
                  DPC_SRC_PC_EX_Q: dpc_d = pc_ex_q;
                  DPC_SRC_NEXT_PC: dpc_d = bus.next_pc_ex;
                  default:         dpc_d = bus.pc_ex;
               endcase
               cause_d    = arb_cause;
               cnt_d      = '0;
               pipe_flush = 1'b1;
               state_d    = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Counting the incremented value bounds DRAIN to DRAIN_MAX cycles.
            cnt_d = cnt_q + 1'b1;
            if (bus.pipe_idle || (cnt_d == CNT_W'(DRAIN_MAX))) begin
               state_d = ST_HALTED;
            end
         end
         ST_HALTED: begin
            if (bus.dpc_wr) begin
               dpc_d = bus.dpc_wr_data;
            end
            if (bus.resumereq || bus.dret_ex) begin
               state_d = ST_RESUME;
            end
         end
         ST_RESUME: begin
            state_d = bus.dcsr_step ? ST_STEP : ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State, captured CSRs and outputs registered from the next state.
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state_q       <= ST_RUN;
         dpc_q         <= '0;
         cause_q       <= CAUSE_NONE;
         pc_ex_q       <= '0;
         cnt_q         <= '0;
         dbg_mode_q    <= 1'b0;
         halted_q      <= 1'b0;
         resumeack_q   <= 1'b0;
         pipe_stall_q  <= 1'b0;
         pc_redirect_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         dpc_q         <= dpc_d;
         cause_q       <= cause_d;
         pc_ex_q       <= bus.pc_ex;
         cnt_q         <= cnt_d;
         dbg_mode_q    <= (state_d == ST_HALTED);
         halted_q      <= (state_d == ST_HALTED);
         resumeack_q   <= (state_d == ST_RESUME);
         pipe_stall_q  <= (state_d == ST_DRAIN) || (state_d == ST_HALTED);
         pc_redirect_q <= (state_d == ST_RESUME);
      end
   end

   assign bus.dbg_mode         = dbg_mode_q;
   assign bus.halted           = halted_q;
   assign bus.resumeack        = resumeack_q;
   assign bus.pipe_stall       = pipe_stall_q;
   assign bus.pc_redirect      = pc_redirect_q;
   assign bus.pipe_flush       = pipe_flush;
   assign bus.pc_redirect_addr = dpc_q;
   assign bus.dpc              = dpc_q;
   assign bus.dcsr_cause       = cause_q;
   assign dbg_state            = state_q;

endmodule

// File: tb/tb_dbg_mode_ctrl.sv
// Directed bench for dbg_mode_ctrl. Inputs change 1 ns after the rising
// edge; registered outputs are read there, pipe_flush 1 ns later.
module tb_dbg_mode_ctrl;
   import dbg_mode_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   dbg_state_e dbg_state;
   int         tests_run = 0;
   int         tests_failed = 0;

   dbg_mode_ctrl_if #(.ADDR_WIDTH(32)) bus ();

   dbg_mode_ctrl #(.ADDR_WIDTH(32), .DRAIN_MAX(15)) dut (
      .cpu_clk   (clk),
      .cpu_rst   (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Clock and reset.
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.breakpoint   = 1'b0;
      bus.ebreak_ex    = 1'b0;
      bus.haltreq      = 1'b0;
      bus.resumereq    = 1'b0;
      bus.dret_ex      = 1'b0;
      bus.dcsr_step    = 1'b0;
      bus.pc_ex        = '0;
      bus.next_pc_ex   = '0;
      bus.instr_retire = 1'b0;
      bus.pipe_idle    = 1'b0;
      bus.dpc_wr       = 1'b0;
      bus.dpc_wr_data  = '0;
   endtask

   // Driver: halt via haltreq at the given PC, pipeline idle in DRAIN.
   task automatic drive_halt(input logic [31:0] pc);
      bus.pc_ex   = pc;
      bus.haltreq = 1'b1;
      tick();
      bus.haltreq   = 1'b0;
      bus.pipe_idle = 1'b1;
      tick();
      bus.pipe_idle = 1'b0;
   endtask

   // Driver: one-cycle resume request, ends in RUN (or STEP).
   task automatic drive_resume();
      bus.resumereq = 1'b1;
      tick();
      bus.resumereq = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tests_run++;
      if (dbg_state !== ST_RUN) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_RUN); end
      tests_run++;
      if ({bus.dbg_mode, bus.halted, bus.resumeack, bus.pipe_stall, bus.pc_redirect} !== 5'b0) begin
         tests_failed++; $display("FAIL reset_outputs: got %b want 00000", {bus.dbg_mode, bus.halted, bus.resumeack, bus.pipe_stall, bus.pc_redirect});
      end
      tests_run++;
      if (bus.dpc !== 32'h0 || bus.dcsr_cause !== 3'd0) begin tests_failed++; $display("FAIL reset_csrs: got dpc=%0h cause=%0d want 0/0", bus.dpc, bus.dcsr_cause); end
   endtask

   task automatic test_trigger_entry();
      bus.pc_ex = 32'h100;           // cycle n
      tick();
      bus.pc_ex = 32'h104;           // cycle n+1: breakpoint for 0x100
      bus.breakpoint = 1'b1;
      #1;
      tests_run++;
      if (bus.pipe_flush !== 1'b1) begin tests_failed++; $display("FAIL trig_flush: got %b want 1", bus.pipe_flush); end
      tick();                        // cycle n+2
      bus.breakpoint = 1'b0;
      tests_run++;
      if (bus.dpc !== 32'h100 || bus.dcsr_cause !== 3'd2) begin tests_failed++; $display("FAIL trig_capture: got dpc=%0h cause=%0d want 100/2", bus.dpc, bus.dcsr_cause); end
      tests_run++;
      if (dbg_state !== ST_DRAIN || bus.pipe_stall !== 1'b1 || bus.dbg_mode !== 1'b0) begin
         tests_failed++; $display("FAIL trig_drain: got state=%0d stall=%b dbg=%b want 1/1/0", dbg_state, bus.pipe_stall, bus.dbg_mode);
      end
      tick();                        // cycle n+3
      bus.pipe_idle = 1'b1;
      tests_run++;
      if (bus.dbg_mode !== 1'b0) begin tests_failed++; $display("FAIL trig_dbg_early: got %b want 0", bus.dbg_mode); end
      tick();                        // cycle n+4
      bus.pipe_idle = 1'b0;
      tests_run++;
      if (bus.dbg_mode !== 1'b1 || bus.halted !== 1'b1 || bus.pipe_stall !== 1'b1) begin
         tests_failed++; $display("FAIL trig_halted: got dbg=%b halted=%b stall=%b want 1/1/1", bus.dbg_mode, bus.halted, bus.pipe_stall);
      end
      // Entry events in HALTED are ignored.
      bus.breakpoint = 1'b1;
      bus.haltreq    = 1'b1;
      #1;
      tests_run++;
      if (bus.pipe_flush !== 1'b0) begin tests_failed++; $display("FAIL halted_no_flush: got %b want 0", bus.pipe_flush); end
      tick();
      bus.breakpoint = 1'b0;
      bus.haltreq    = 1'b0;
      tests_run++;
      if (dbg_state !== ST_HALTED || bus.dcsr_cause !== 3'd2) begin tests_failed++; $display("FAIL halted_ignore: got state=%0d cause=%0d want 2/2", dbg_state, bus.dcsr_cause); end
      bus.resumereq = 1'b1;
      tick();
      bus.resumereq = 1'b0;
      tests_run++;
      if (bus.pc_redirect !== 1'b1 || bus.pc_redirect_addr !== 32'h100 || bus.resumeack !== 1'b1 || bus.dbg_mode !== 1'b0) begin
         tests_failed++; $display("FAIL trig_resume: got redir=%b addr=%0h ack=%b dbg=%b want 1/100/1/0", bus.pc_redirect, bus.pc_redirect_addr, bus.resumeack, bus.dbg_mode);
      end
      tick();
      tests_run++;
      if (dbg_state !== ST_RUN || bus.resumeack !== 1'b0 || bus.pc_redirect !== 1'b0) begin
         tests_failed++; $display("FAIL trig_back_run: got state=%0d ack=%b redir=%b want 0/0/0", dbg_state, bus.resumeack, bus.pc_redirect);
      end
   endtask

   task automatic test_priority();
      bus.pc_ex = 32'h2f0;
      tick();
      bus.pc_ex = 32'h300;
      bus.breakpoint = 1'b1;
      bus.ebreak_ex  = 1'b1;
      bus.haltreq    = 1'b1;
      tick();
      idle_inputs();
      tests_run++;
      if (bus.dcsr_cause !== 3'd2 || bus.dpc !== 32'h2f0) begin tests_failed++; $display("FAIL prio_all: got cause=%0d dpc=%0h want 2/2f0", bus.dcsr_cause, bus.dpc); end
      bus.pipe_idle = 1'b1;
      tick();
      bus.pipe_idle = 1'b0;
      drive_resume();
      bus.pc_ex     = 32'h400;
      bus.ebreak_ex = 1'b1;
      bus.haltreq   = 1'b1;
      tick();
      idle_inputs();
      tests_run++;
      if (bus.dcsr_cause !== 3'd1 || bus.dpc !== 32'h400) begin tests_failed++; $display("FAIL prio_ebreak: got cause=%0d dpc=%0h want 1/400", bus.dcsr_cause, bus.dpc); end
      bus.pipe_idle = 1'b1;
      tick();
      bus.pipe_idle = 1'b0;
      drive_resume();
      drive_halt(32'h480);
      tests_run++;
      if (bus.dcsr_cause !== 3'd3 || bus.dpc !== 32'h480 || bus.halted !== 1'b1) begin
         tests_failed++; $display("FAIL prio_haltreq: got cause=%0d dpc=%0h halted=%b want 3/480/1", bus.dcsr_cause, bus.dpc, bus.halted);
      end
      drive_resume();
   endtask

   task automatic test_drain_timeout();
      int n;
      bus.pc_ex   = 32'h500;
      bus.haltreq = 1'b1;
      #1;
      tests_run++;
      if (bus.pipe_flush !== 1'b1) begin tests_failed++; $display("FAIL timeout_flush: got %b want 1", bus.pipe_flush); end
      tick();
      bus.haltreq = 1'b0;
      n = 1;
      while (bus.halted !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      tests_run++;
      if (n !== 16) begin tests_failed++; $display("FAIL timeout_cycles: got %0d want 16", n); end
      tests_run++;
      if (dbg_state !== ST_HALTED || bus.dpc !== 32'h500) begin tests_failed++; $display("FAIL timeout_state: got state=%0d dpc=%0h want 2/500", dbg_state, bus.dpc); end
   endtask

   task automatic test_resume_dpc_wr();
      bus.dpc_wr      = 1'b1;
      bus.dpc_wr_data = 32'h200;
      bus.resumereq   = 1'b1;
      tick();
      bus.dpc_wr = 1'b0;
      tests_run++;
      if (bus.pc_redirect !== 1'b1 || bus.pc_redirect_addr !== 32'h200 || bus.resumeack !== 1'b1 || bus.dbg_mode !== 1'b0) begin
         tests_failed++; $display("FAIL wr_resume: got redir=%b addr=%0h ack=%b dbg=%b want 1/200/1/0", bus.pc_redirect, bus.pc_redirect_addr, bus.resumeack, bus.dbg_mode);
      end
      tick();                        // resumereq still held
      tests_run++;
      if (dbg_state !== ST_RUN || bus.resumeack !== 1'b0 || bus.pc_redirect !== 1'b0) begin
         tests_failed++; $display("FAIL wr_held_req: got state=%0d ack=%b redir=%b want 0/0/0", dbg_state, bus.resumeack, bus.pc_redirect);
      end
      bus.resumereq = 1'b0;
      bus.dret_ex   = 1'b1;
      tick();
      bus.dret_ex = 1'b0;
      tests_run++;
      if (dbg_state !== ST_RUN || bus.pc_redirect !== 1'b0) begin tests_failed++; $display("FAIL dret_in_run: got state=%0d redir=%b want 0/0", dbg_state, bus.pc_redirect); end
      // dret from HALTED redirects like a resume.
      drive_halt(32'h600);
      bus.dret_ex = 1'b1;
      tick();
      bus.dret_ex = 1'b0;
      tests_run++;
      if (bus.pc_redirect !== 1'b1 || bus.pc_redirect_addr !== 32'h600) begin tests_failed++; $display("FAIL dret_resume: got redir=%b addr=%0h want 1/600", bus.pc_redirect, bus.pc_redirect_addr); end
      tick();
   endtask

   task automatic test_single_step();
      drive_halt(32'h1f0);
      bus.dcsr_step = 1'b1;
      drive_resume();
      tests_run++;
      if (dbg_state !== ST_STEP || bus.dbg_mode !== 1'b0) begin tests_failed++; $display("FAIL step_state: got state=%0d dbg=%b want 4/0", dbg_state, bus.dbg_mode); end
      bus.haltreq = 1'b1;
      #1;
      tests_run++;
      if (bus.pipe_flush !== 1'b0) begin tests_failed++; $display("FAIL step_haltreq_defer: got flush=%b want 0", bus.pipe_flush); end
      tick();
      bus.instr_retire = 1'b1;
      bus.next_pc_ex   = 32'h204;
      bus.pc_ex        = 32'h200;
      #1;
      tests_run++;
      if (bus.pipe_flush !== 1'b1) begin tests_failed++; $display("FAIL step_flush: got %b want 1", bus.pipe_flush); end
      tick();
      bus.instr_retire = 1'b0;
      bus.pipe_idle    = 1'b1;
      tests_run++;
      if (bus.dcsr_cause !== 3'd4 || bus.dpc !== 32'h204 || dbg_state !== ST_DRAIN) begin
         tests_failed++; $display("FAIL step_capture: got cause=%0d dpc=%0h state=%0d want 4/204/1", bus.dcsr_cause, bus.dpc, dbg_state);
      end
      tick();
      idle_inputs();
      tests_run++;
      if (bus.halted !== 1'b1 || bus.dcsr_cause !== 3'd4) begin tests_failed++; $display("FAIL step_halted: got halted=%b cause=%0d want 1/4", bus.halted, bus.dcsr_cause); end
      drive_resume();
      tests_run++;
      if (dbg_state !== ST_RUN || bus.dcsr_cause !== 3'd4) begin tests_failed++; $display("FAIL cause_kept: got state=%0d cause=%0d want 0/4", dbg_state, bus.dcsr_cause); end
   endtask

   task automatic test_reset_in_halted();
      drive_halt(32'h700);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests_run++;
      if (bus.dbg_mode !== 1'b0 || bus.halted !== 1'b0 || bus.dpc !== 32'h0 || dbg_state !== ST_RUN || bus.dcsr_cause !== 3'd0) begin
         tests_failed++; $display("FAIL reset_halted: got dbg=%b halted=%b dpc=%0h state=%0d cause=%0d want 0/0/0/0/0",
                                  bus.dbg_mode, bus.halted, bus.dpc, dbg_state, bus.dcsr_cause);
      end
   endtask

   initial begin
      test_reset();
      test_trigger_entry();
      test_priority();
      test_drain_timeout();
      test_resume_dpc_wr();
      test_single_step();
      test_reset_in_halted();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
